// File: rtl/md_rom_loader.sv
// md_rom_loader: packs the iosys ROM byte stream into big-endian 16-bit SDRAM writes
// and gates the core run enable. Define MD_ROM_LOADER_CHECKSUM_EN for the checksum ports.
module md_rom_loader #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BYTES  = 8388608
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        md_on,
  output logic [22:0] rom_size,
  output logic        overflow,
  output logic        busy
`ifdef MD_ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum,
  output logic        checksum_ok
`endif
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          EW      = 40;
  localparam logic [23:0] MAX_CNT = 24'(MAX_BYTES);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t        state_q;
  logic [2:0]    loading_q;
  logic          primed_q;
  logic [23:0]   cnt_q;
  logic [7:0]    hi_q;
  logic          overflow_q;
  logic          md_on_q;
  logic [22:0]   rom_size_q;
  logic          busy_q;
  logic [21:0]   mem_addr_q;
  logic [15:0]   mem_din_q;
  logic [1:0]    mem_be_q;
  logic          mem_req_q;

  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;

  logic          rise_s;
  logic          fall_s;
  logic          empty_s;
  logic          full_s;
  logic          req_idle_s;
  logic          byte_ok_s;
  logic          accept_s;
  logic          drop_s;
  logic          push_req_s;
  logic          push_s;
  logic          push_drop_s;
  logic          pop_s;
  logic          run_entry_s;
  logic [21:0]   push_addr_d;
  logic [15:0]   push_data_d;
  logic [1:0]    push_be_d;
  logic [EW-1:0] push_word_d;
  logic [EW-1:0] head_s;
  logic [22:0]   size_sat_s;

  // Edge detection, byte acceptance, FIFO push/pop decisions and run entry.
  always_comb begin
    rise_s      = (loading_q == 3'd0) && (loading != 3'd0);
    fall_s      = (loading_q != 3'd0) && (loading == 3'd0);
    empty_s     = (wr_ptr_q == rd_ptr_q);
    full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    req_idle_s  = (mem_req_q == mem_ack);
    byte_ok_s   = (state_q == ST_LOAD) && rom_do_valid && (loading == 3'd1);
    accept_s    = byte_ok_s && (cnt_q < MAX_CNT);
    drop_s      = byte_ok_s && !(cnt_q < MAX_CNT);
    push_addr_d = cnt_q[22:1];
    push_data_d = {hi_q, rom_do};
    push_be_d   = 2'b11;
    push_req_s  = 1'b0;
    if (accept_s && cnt_q[0]) begin
      push_req_s = 1'b1;
    end else if ((state_q == ST_LOAD) && fall_s && cnt_q[0]) begin
      push_req_s  = 1'b1;
      push_data_d = {hi_q, 8'h00};
      push_be_d   = 2'b10;
    end else begin
      push_req_s = 1'b0;
    end
    push_word_d = {push_addr_d, push_data_d, push_be_d};
    head_s      = fifo_mem_q[rd_ptr_q[AW-1:0]];
    // A rise flushes the FIFO, so nothing stale may be issued on that cycle.
    pop_s       = !empty_s && req_idle_s && !rise_s;
    push_s      = push_req_s && (!full_s || pop_s);
    push_drop_s = push_req_s && full_s && !pop_s;
    if (rise_s) begin
      run_entry_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      run_entry_s = primed_q && (loading == 3'd0) && empty_s;
    end else if (state_q == ST_FLUSH) begin
      run_entry_s = empty_s && req_idle_s;
    end else begin
      run_entry_s = 1'b0;
    end
    size_sat_s = cnt_q[23] ? 23'h7F_FFFF : cnt_q[22:0];
  end

  // Word FIFO storage and pointers; a load rise discards anything not yet issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else if (rise_s) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_word_d;
        wr_ptr_q                     <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Load sequencing, byte packing, write issue and the registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      loading_q  <= 3'd0;
      primed_q   <= 1'b0;
      cnt_q      <= 24'd0;
      hi_q       <= 8'h00;
      overflow_q <= 1'b0;
      md_on_q    <= 1'b0;
      rom_size_q <= 23'd0;
      busy_q     <= 1'b0;
      mem_addr_q <= 22'd0;
      mem_din_q  <= 16'h0000;
      mem_be_q   <= 2'b00;
      mem_req_q  <= 1'b0;
    end else begin
      loading_q <= loading;
      primed_q  <= 1'b1;
      if (pop_s) begin
        mem_addr_q <= head_s[39:18];
        mem_din_q  <= head_s[17:2];
        mem_be_q   <= head_s[1:0];
        mem_req_q  <= ~mem_req_q;
      end
      if (rise_s) begin
        state_q    <= ST_LOAD;
        busy_q     <= 1'b1;
        md_on_q    <= 1'b0;
        cnt_q      <= 24'd0;
        hi_q       <= 8'h00;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_entry_s) begin
              state_q    <= ST_RUN;
              md_on_q    <= 1'b1;
              rom_size_q <= 23'd0;
              busy_q     <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (accept_s) begin
              cnt_q <= cnt_q + 24'd1;
              if (!cnt_q[0]) begin
                hi_q <= rom_do;
              end
            end
            if (drop_s || push_drop_s) begin
              overflow_q <= 1'b1;
            end
            if (fall_s) begin
              state_q <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            if (run_entry_s) begin
              state_q    <= ST_RUN;
              md_on_q    <= 1'b1;
              rom_size_q <= size_sat_s;
              busy_q     <= 1'b0;
            end
          end
          ST_RUN: begin
            state_q <= ST_RUN;
          end
          default: begin
            state_q <= ST_IDLE;
            md_on_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef MD_ROM_LOADER_CHECKSUM_EN
  logic [15:0] csum_q;
  logic [15:0] hdr_sum_q;
  logic        csum_ok_q;

  // Running sum of packed words from byte 0x200 on, header word 0x18E, and the compare.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csum_q    <= 16'h0000;
      hdr_sum_q <= 16'h0000;
      csum_ok_q <= 1'b0;
    end else if (rise_s) begin
      csum_q    <= 16'h0000;
      hdr_sum_q <= 16'h0000;
    end else begin
      if (push_req_s && (push_addr_d >= 22'h00_0100)) begin
        csum_q <= csum_q + push_data_d;
      end
      if (push_req_s && (push_addr_d == 22'h00_00C7)) begin
        hdr_sum_q <= push_data_d;
      end
      if (run_entry_s) begin
        csum_ok_q <= (csum_q == hdr_sum_q);
      end
    end
  end

  assign checksum    = csum_q;
  assign checksum_ok = csum_ok_q;
`endif

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_be   = mem_be_q;
  assign mem_req  = mem_req_q;
  assign md_on    = md_on_q;
  assign rom_size = rom_size_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: doc/md_rom_loader.md
Name: md_rom_loader

Overview:
- Sits between the iosys ROM byte stream and SDRAM client port 1.
- Packs incoming bytes into big-endian 16-bit words and buffers them in a small FIFO.
- Issues SDRAM writes over the toggle req/ack handshake.
- Tracks ROM size and drives the Mega Drive run enable (md_on), held off while loading and until every write has been acknowledged.

Parameters:
- FIFO_DEPTH, 8: word FIFO entries; power of two, at least 2.
- MAX_BYTES, 8388608: byte capacity of the cartridge ROM region; bytes beyond it are dropped.

Ports:
- clk  in  1  system clock (clk_sys domain)
- resetn  in  1  asynchronous active-low reset
- loading  in  3  iosys load mode; 0 = run, 1 = ROM load, other values = non-ROM load
- rom_do  in  8  ROM byte from iosys
- rom_do_valid  in  1  one-cycle strobe, rom_do valid
- mem_addr  out  22  SDRAM word address (bits 22:1)
- mem_din  out  16  write data; even byte in [15:8], odd byte in [7:0]
- mem_be  out  2  byte enables; 11 = full word, 10 = high byte only
- mem_req  out  1  toggle request
- mem_ack  in  1  toggle acknowledge
- md_on  out  1  core run enable
- rom_size  out  23  loaded byte count, valid when md_on = 1
- overflow  out  1  sticky: at least one byte was dropped
- busy  out  1  high while in LOAD or FLUSH

Behaviour:
- Reset values: mem_addr 0, mem_din 0, mem_be 00, mem_req 0, md_on 0, rom_size 0, overflow 0, busy 0. FSM enters IDLE, FIFO empties, packer clears.
- State machine: IDLE, LOAD, FLUSH, RUN.
- loading is registered once (loading_r). Edge detection uses loading vs loading_r.
- Rise (loading_r = 0, loading != 0), from any state:
  - md_on <= 0; byte count, FIFO, packer and overflow cleared.
  - Go to LOAD.
  - Any outstanding req/ack toggle is still honoured: no new request is issued until req == ack.
- In LOAD, a byte is accepted only when rom_do_valid = 1 and loading = 1. Other nonzero loading values ignore bytes.
- Byte count below MAX_BYTES:
  - Even count: byte latched as high half.
  - Odd count: word {high, rom_do} with be 11 and address count[22:1] pushed to FIFO.
  - Count increments by 1 in both cases.
- Byte count at MAX_BYTES: byte dropped, overflow <= 1.
- FIFO full at push: word dropped, overflow <= 1, count still increments.
- Fall (loading_r != 0, loading = 0) in LOAD:
  - If a half word is pending, push it with be 10 (same full/drop rule).
  - Go to FLUSH.
- FLUSH: when FIFO empty and mem_req == mem_ack:
  - rom_size <= count; md_on <= 1; go to RUN.
  - Latency from fall edge to md_on is at least 2 cycles plus drain time.
- Write engine, in any state: when FIFO not empty and mem_req == mem_ack:
  - Pop the FIFO into mem_addr/mem_din/mem_be and toggle mem_req, all in the same cycle.
  - Outputs hold until the next pop.
  - At most one request in flight.
- Push and pop in the same cycle are allowed. Occupancy is unchanged; a full FIFO accepts the push.
- IDLE to RUN: the first observed cycle with loading = 0 after reset, with empty FIFO, sets md_on = 1 and rom_size = 0.
- busy = (state == LOAD) or (state == FLUSH).
- Count width is 23 bits; it saturates and never wraps.

Optional Feature:
- Macro: MD_ROM_LOADER_CHECKSUM_EN.
- When defined, adds output ports checksum (16) and checksum_ok (1).
- checksum is the 16-bit wrapping sum of all packed words whose byte address is >= 0x200, including a trailing be 10 word with low byte 0.
- The header word at byte address 0x18E is latched as hdr_sum.
- Both checksum and hdr_sum clear on the load rise edge.
- checksum_ok <= (checksum == hdr_sum), updated on entry to RUN; reset value 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release with loading = 0 -> md_on = 1 after 2 cycles, rom_size = 0, mem_req = 0.
- Load 4 bytes 12 34 56 78, ack echoed 3 cycles after each req:
  - Writes: addr 0 din 1234 be 11, then addr 1 din 5678 be 11.
  - rom_size = 4; md_on = 1 only after the second ack.
- Load 3 bytes AA BB CC, then drop loading:
  - Final write addr 1 din CCxx be 10.
  - rom_size = 3.
- Hold mem_ack static, stream 2*FIFO_DEPTH+6 bytes:
  - After the FIFO fills, overflow = 1 and md_on stays 0.
  - Releasing ack drains exactly FIFO_DEPTH+1 writes.
- Restart mid-load (loading 1 -> 0 -> 1 within FLUSH):
  - md_on stays 0 and the count restarts at 0.
  - The in-flight request completes before any new request.
- MD_ROM_LOADER_CHECKSUM_EN, 0x204-byte image: header word 0x18E = 0003, words at 0x200 = 0001 and 0x202 = 0002 -> checksum = 0003, checksum_ok = 1.
